// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/result bundle for the nibble-serial adder.
//   master : requester side (drives start/a/b/cin, observes busy/done/sum/cout)
//   slave  : controller side (serial_add_ctrl)
// Signals:
//   start     request, accepted only while the controller is idle
//   a, b      W-bit operands, W = 4*NIBBLES
//   cin       carry-in to the lowest nibble
//   busy      high while the serial add is running
//   done      one-cycle completion pulse
//   sum, cout registered result of the last completed add
interface serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// nibble_adder4: combinational 4-bit ripple-carry adder slice.
//   a_i, b_i, c_i -> s_o, c_o
//
// serial_add_ctrl: adds two 4*NIBBLES-bit operands plus carry-in through one
// shared 4-bit ripple stage, one nibble per clock, LSB nibble first.
//   clk    rising-edge clock
//   reset  synchronous active-high reset; aborts an add in progress
//   bus    serial_add_ctrl_if.slave (start/a/b/cin in, busy/done/sum/cout out)
//
// state  | meaning
// S_IDLE | waiting for start; operands are captured on the accepting edge
// S_RUN  | one nibble per cycle through the shared adder, idx selects slice
// S_DONE | result registered, done pulses for this single cycle

module nibble_adder4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    always_comb begin
        logic [4:0] c;
        c    = '0;
        s_o  = '0;
        c[0] = c_i;
        for (int i = 0; i < 4; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
            c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        c_o = c[4];
    end
endmodule

module serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    serial_add_ctrl_if.slave   bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = ($clog2(NIBBLES + 1) < 1) ? 1 : $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  ra_q, ra_d;
    logic [W-1:0]  rb_q, rb_d;
    logic          rc_q, rc_d;
    logic [W-1:0]  rs_q, rs_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;

    logic [3:0]    nib_a, nib_b, nib_s;
    logic          nib_c;

    // Slice select written as a compare loop so idx can be wider than the
    // slice count without an out-of-range part-select.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                nib_a = ra_q[4*i +: 4];
                nib_b = rb_q[4*i +: 4];
            end
        end
    end

    nibble_adder4 u_add (
        .a_i (nib_a),
        .b_i (nib_b),
        .c_i (rc_q),
        .s_o (nib_s),
        .c_o (nib_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= 1'b0;
            rs_q    <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            rs_q    <= rs_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        rs_d    = rs_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    rc_d    = bus.cin;
                    rs_d    = '0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) begin
                        rs_d[4*i +: 4] = nib_s;
                    end
                end
                rc_d  = nib_c;
                idx_d = idx_q + 1'b1;
                // Last slice: publish the work register including this nibble.
                if (idx_q == IW'(NIBBLES - 1)) begin
                    sum_d   = rs_d;
                    cout_d  = nib_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl with NIBBLES=4: directed vector table,
// hand-written corner sequences and random operands against a + b + cin.
module tb_serial_add_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk;
    logic reset;

    serial_add_ctrl_if #(.NIBBLES(N)) bus ();

    serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Enter just after a negedge with the DUT idle; leaves just after the
    // negedge that follows E0+5 with the DUT idle again and start low.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] es, input logic ec, input bit mess);
        logic [W-1:0] prev_s;
        logic         prev_c;
        prev_s    = bus.sum;
        prev_c    = bus.cout;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        @(negedge clk);
        for (int k = 0; k <= 5; k++) begin
            if (k < 4) begin
                check("busy_run", 32'(bus.busy), 32'd1);
                check("done_run", 32'(bus.done), 32'd0);
                check("sum_hold", 32'(bus.sum), 32'(prev_s));
                check("cout_hold", 32'(bus.cout), 32'(prev_c));
            end else if (k == 4) begin
                check("busy_done", 32'(bus.busy), 32'd0);
                check("done_pulse", 32'(bus.done), 32'd1);
                check("sum", 32'(bus.sum), 32'(es));
                check("cout", 32'(bus.cout), 32'(ec));
            end else begin
                check("done_end", 32'(bus.done), 32'd0);
                check("busy_end", 32'(bus.busy), 32'd0);
                check("sum_keep", 32'(bus.sum), 32'(es));
            end
            if (mess && k <= 4) begin
                bus.start = 1'b1;
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
                bus.cin   = 1'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            if (k < 5) @(negedge clk);
        end
    endtask

    initial begin
        logic [W:0]   ref_full;
        logic [W-1:0] ra, rb;
        logic         rcin;
        int           last_done;
        int           n_done;

        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b1, s: 16'h5556, c: 1'b0};
        vecs[1] = '{a: 16'h0FFF, b: 16'h0001, cin: 1'b0, s: 16'h1000, c: 1'b0};
        vecs[2] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, s: 16'h0000, c: 1'b1};
        vecs[3] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, s: 16'hFFFF, c: 1'b1};
        vecs[4] = '{a: 16'h0000, b: 16'h0000, cin: 1'b0, s: 16'h0000, c: 1'b0};
        vecs[5] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, s: 16'h0000, c: 1'b1};
        vecs[6] = '{a: 16'h0000, b: 16'hFFFF, cin: 1'b1, s: 16'h0000, c: 1'b1};

        reset     = 1'b1;
        bus.start = 1'b1;
        bus.a     = 16'hAAAA;
        bus.b     = 16'h5555;
        bus.cin   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        reset     = 1'b0;
        bus.start = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(bus.busy), 32'd0);
            check("idle_done", 32'(bus.done), 32'd0);
            check("idle_sum", 32'(bus.sum), 32'd0);
            check("idle_cout", 32'(bus.cout), 32'd0);
        end

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, 1'b0);
        end

        // Operands and start toggled during RUN/DONE must be ignored.
        run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b1);

        // Reset on the second RUN cycle aborts without done.
        bus.start = 1'b1;
        bus.a     = 16'h0FFF;
        bus.b     = 16'h0001;
        bus.cin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_idle_sum", 32'(bus.sum), 32'd0);
        run_op(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Held start: one result every 6 cycles.
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h4321;
        bus.cin   = 1'b1;
        last_done = -1;
        n_done    = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                check("b2b_sum", 32'(bus.sum), 32'h5556);
                check("b2b_cout", 32'(bus.cout), 32'd0);
                if (last_done < 0) check("b2b_first", 32'(i), 32'd4);
                else check("b2b_interval", 32'(i - last_done), 32'd6);
                last_done = i;
            end
        end
        check("b2b_count", 32'(n_done), 32'd6);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("b2b_drain_busy", 32'(bus.busy), 32'd0);

        // Random operands against plain arithmetic.
        for (int i = 0; i < 40; i++) begin
            ra       = W'($urandom);
            rb       = W'($urandom);
            rcin     = 1'($urandom);
            ref_full = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rcin);
            run_op(ra, rb, rcin, ref_full[W-1:0], ref_full[W], ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
